// File: rtl/d_flipflop_sync_edge.sv
// Purpose: synchronise an async 1-bit input, optionally debounce it, emit clean level, rise/fall pulses, rise count.
// Latency: q follows d SYNC_STAGES+1 edges after capture (plus FILTER_CYCLES with D_FLIPFLOP_SYNC_FILTER_EN).
// Backpressure: none; the input is sampled every cycle and outputs are plain registered levels/pulses.
module d_flipflop_sync_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   d,
    output logic                   q,
    output logic                   qbar,
    output logic                   rise,
    output logic                   fall,
    output logic [COUNT_WIDTH-1:0] edge_count
);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_bad_filter
        $error("FILTER_CYCLES must be in 1..65535");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Plain flop chain; nothing between stages so each stage gets a full cycle to resolve.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

`ifdef D_FLIPFLOP_SYNC_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES) + 1;
    localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        QUAL_HIGH = 2'd1,
        HIGH      = 2'd2,
        QUAL_LOW  = 2'd3
    } state_t;

    logic [FW-1:0] cnt, cnt_nxt;
`else
    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;
`endif

    state_t                 state, state_nxt;
    logic                   q_nxt, qbar_nxt, rise_nxt, fall_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;

    // State and every output are registered so q/qbar/pulses/count all change on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOW;
            q          <= 1'b0;
            qbar       <= 1'b1;
            rise       <= 1'b0;
            fall       <= 1'b0;
            edge_count <= '0;
`ifdef D_FLIPFLOP_SYNC_FILTER_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            qbar       <= qbar_nxt;
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            edge_count <= count_nxt;
`ifdef D_FLIPFLOP_SYNC_FILTER_EN
            cnt        <= cnt_nxt;
`endif
        end
    end

    // Next-state logic: a level is accepted only once s has held long enough; pulses default low.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        qbar_nxt  = qbar;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        count_nxt = edge_count;
`ifdef D_FLIPFLOP_SYNC_FILTER_EN
        cnt_nxt   = cnt;
        case (state)
            LOW: begin
                if (s) begin
                    state_nxt = QUAL_HIGH;
                    cnt_nxt   = '0;
                end
            end
            QUAL_HIGH: begin
                if (!s) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    q_nxt     = 1'b1;
                    qbar_nxt  = 1'b0;
                    rise_nxt  = 1'b1;
                    count_nxt = edge_count + COUNT_WIDTH'(1);
                end else begin
                    cnt_nxt = cnt + FW'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_nxt = QUAL_LOW;
                    cnt_nxt   = '0;
                end
            end
            QUAL_LOW: begin
                if (s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    q_nxt     = 1'b0;
                    qbar_nxt  = 1'b1;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + FW'(1);
                end
            end
            default: begin
                state_nxt = LOW;
            end
        endcase
`else
        case (state)
            LOW: begin
                if (s) begin
                    state_nxt = HIGH;
                    q_nxt     = 1'b1;
                    qbar_nxt  = 1'b0;
                    rise_nxt  = 1'b1;
                    count_nxt = edge_count + COUNT_WIDTH'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_nxt = LOW;
                    q_nxt     = 1'b0;
                    qbar_nxt  = 1'b1;
                    fall_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = LOW;
            end
        endcase
`endif
    end

endmodule

// File: tb/tb_d_flipflop_sync_edge.sv
// Directed bench for d_flipflop_sync_edge; expectations follow D_FLIPFLOP_SYNC_FILTER_EN.
module tb_d_flipflop_sync_edge;

    localparam int SS = 2;
    localparam int F  = 4;
    localparam int CW = 8;
`ifdef D_FLIPFLOP_SYNC_FILTER_EN
    localparam int FILT = F;
`else
    localparam int FILT = 0;
`endif
    // Edge index (first edge after d changes = 1) on which q/rise/fall update.
    localparam int QE = 1 + SS + FILT;

    logic          clock;
    logic          reset_n;
    logic          d;
    logic          q;
    logic          qbar;
    logic          rise;
    logic          fall;
    logic [CW-1:0] edge_count;

    int            tests;
    int            fails;
    logic [CW-1:0] exp_cnt;

    d_flipflop_sync_edge #(
        .SYNC_STAGES  (SS),
        .FILTER_CYCLES(F),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .d         (d),
        .q         (q),
        .qbar      (qbar),
        .rise      (rise),
        .fall      (fall),
        .edge_count(edge_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check qbar tracks q.
    task automatic tick();
        @(posedge clock);
        #1;
        chk("qbar_inv", {31'b0, qbar}, {31'b0, ~q});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q"},    {31'b0, q},    32'd0);
        chk({tag, "_qbar"}, {31'b0, qbar}, 32'd1);
        chk({tag, "_rise"}, {31'b0, rise}, 32'd0);
        chk({tag, "_fall"}, {31'b0, fall}, 32'd0);
        chk({tag, "_cnt"},  {24'b0, edge_count}, 32'd0);
    endtask

    // d has just gone high (or sync was just released with d high): expect rise exactly at edge QE.
    task automatic expect_rise(input string tag);
        exp_cnt = exp_cnt + 1'b1;
        for (int i = 1; i <= QE + 1; i++) begin
            tick();
            chk({tag, "_q"},    {31'b0, q},    (i >= QE) ? 32'd1 : 32'd0);
            chk({tag, "_rise"}, {31'b0, rise}, (i == QE) ? 32'd1 : 32'd0);
        end
        chk({tag, "_cnt"}, {24'b0, edge_count}, {24'b0, exp_cnt});
    endtask

    // A d pulse of p cycles: accepted only if it outlasts the filter.
    task automatic glitch(input int p);
        int nr;
        int nf;
        int both;
        int acc;
        nr   = 0;
        nf   = 0;
        both = 0;
        acc  = (p > FILT) ? 1 : 0;
        d = 1'b1;
        for (int i = 0; i < p; i++) begin
            tick();
            nr += int'(rise);
            nf += int'(fall);
            both += int'(rise & fall);
        end
        d = 1'b0;
        for (int i = 0; i < SS + FILT + 3; i++) begin
            tick();
            nr += int'(rise);
            nf += int'(fall);
            both += int'(rise & fall);
        end
        if (acc != 0) exp_cnt = exp_cnt + 1'b1;
        chk($sformatf("glitch%0d_rises", p), nr, acc);
        chk($sformatf("glitch%0d_falls", p), nf, acc);
        chk($sformatf("glitch%0d_both", p), both, 0);
        chk($sformatf("glitch%0d_cnt", p), {24'b0, edge_count}, {24'b0, exp_cnt});
        chk($sformatf("glitch%0d_q", p), {31'b0, q}, 32'd0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        exp_cnt = '0;
        reset_n = 1'b0;
        d       = 1'b1;

        // Reset held with d high: everything stays at reset values.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_reset_vals("reset");
        end
        d = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_reset_vals("post_release");

        // Rising latency.
        d = 1'b1;
        expect_rise("lat");

        // Falling latency, count unchanged.
        d = 1'b0;
        for (int i = 1; i <= QE + 1; i++) begin
            tick();
            chk("fall_q",    {31'b0, q},    (i >= QE) ? 32'd0 : 32'd1);
            chk("fall_fall", {31'b0, fall}, (i == QE) ? 32'd1 : 32'd0);
            chk("fall_rise", {31'b0, rise}, 32'd0);
        end
        chk("fall_cnt", {24'b0, edge_count}, {24'b0, exp_cnt});

        // Short pulses around the filter boundary.
        glitch(1);
        glitch(3);
        glitch(4);
        glitch(5);

        // Reset two cycles into qualification of a high level.
        d = 1'b1;
        for (int i = 0; i < SS + 3; i++) tick();
        chk("midrst_pre_q", {31'b0, q}, (SS + 3 >= QE) ? 32'd1 : 32'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst_async");
        exp_cnt = '0;
        tick();
        tick();
        chk_reset_vals("midrst_hold");
        reset_n = 1'b1;
        expect_rise("midrst_rel");

        // Return low, then clear the count for the wrap run.
        d = 1'b0;
        for (int i = 0; i < SS + FILT + 3; i++) tick();
        chk("pre_wrap_q", {31'b0, q}, 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_cnt = '0;
        tick();

        // 256 minimum-length accepted pulses: count wraps 255 -> 0.
        for (int n = 1; n <= 256; n++) begin
            d = 1'b1;
            for (int i = 0; i < FILT + 1; i++) tick();
            d = 1'b0;
            for (int i = 0; i < SS + FILT + 3; i++) tick();
            exp_cnt = exp_cnt + 1'b1;
            chk($sformatf("wrap_cnt%0d", n), {24'b0, edge_count}, {24'b0, exp_cnt});
        end
        chk("wrap_final_zero", {24'b0, edge_count}, 32'd0);
        chk("wrap_final_q", {31'b0, q}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
